// File: rtl/vec_exec_sequencer.sv
// vec_exec_sequencer: accepts one 5-bit exec word at a time, decodes it into
// an ALU operation and a unit-enable class, and steps the lane array through
// VLEN/LANES element beats with a per-beat write-back strobe. Every output
// except instr_ready is registered: the next-state logic also computes the
// outputs belonging to the next state, and those values are flopped together.
module vec_exec_sequencer #(
   parameter  int VLEN    = 16,
   parameter  int LANES   = 4,
   parameter  int DIV_CYC = 4,
   localparam int NBEAT   = VLEN / LANES,
   localparam int BW      = (NBEAT > 1) ? $clog2(NBEAT) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [4:0]    exec,
   input  logic          flush,
   output logic [2:0]    alu_op,
   output logic          en_sc,
   output logic          en_vs,
   output logic          en_vv,
   output logic [BW-1:0] beat_idx,
   output logic          wb_en,
   output logic          busy,
   output logic          done
);

   localparam int            CW         = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
   localparam bit            DIV_MULTI  = (DIV_CYC > 1);
   localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEAT - 1);
   localparam logic [CW-1:0] LAST_CYC   = CW'(DIV_CYC - 1);
   localparam logic [2:0]    OP_NOP     = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DIV_WAIT,
      S_DONE
   } state_t;

   // Unit-enable class of the captured word.
   typedef enum logic [2:0] {
      C_NOP,   // func=1
      C_SC,    // scalar, single beat
      C_VS,    // vector-scalar, 1 cycle per beat
      C_VDIV,  // vector-scalar divide, DIV_CYC cycles per beat
      C_VV     // vector-vector, 1 cycle per beat
   } cls_t;

   // Word is {func, opcode}; exec[0] carries no meaning.
   function automatic cls_t decode(input logic [3:0] w);
      cls_t c;
      if (w[3]) begin
         c = C_NOP;
      end else begin
         case (w[2:0])
            3'b001, 3'b100: c = C_VS;
            3'b110:         c = C_VDIV;
            3'b101:         c = C_VV;
            default:        c = C_SC;
         endcase
      end
      return c;
   endfunction

   logic unused_exec_lsb;
   assign unused_exec_lsb = exec[0];

   state_t        state_q, state_d;
   logic [3:0]    word_q, word_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic          en_sc_q, en_sc_d;
   logic          en_vs_q, en_vs_d;
   logic          en_vv_q, en_vv_d;
   logic          wb_en_q, wb_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   cls_t cls_q, cls_d;
   logic last_beat;

   assign cls_q     = decode(word_q);
   assign last_beat = (cls_q == C_SC) || (cls_q == C_NOP) || (beat_q == LAST_BEAT);

   // Next state, captured word, beat and divide-cycle counters.
   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      beat_d  = beat_q;
      cyc_d   = cyc_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               word_d  = exec[4:1];
               beat_d  = '0;
               cyc_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (flush) begin
               state_d = S_IDLE;
               beat_d  = '0;
            end else if ((cls_q == C_VDIV) && DIV_MULTI) begin
               state_d = S_DIV_WAIT;
               cyc_d   = CW'(1);
            end else if (last_beat) begin
               state_d = S_DONE;
               beat_d  = '0;
            end else begin
               beat_d  = beat_q + BW'(1);
            end
         end
         S_DIV_WAIT: begin
            if (flush) begin
               state_d = S_IDLE;
               beat_d  = '0;
               cyc_d   = '0;
            end else if (cyc_q == LAST_CYC) begin
               cyc_d = '0;
               if (beat_q == LAST_BEAT) begin
                  state_d = S_DONE;
                  beat_d  = '0;
               end else begin
                  state_d = S_ISSUE;
                  beat_d  = beat_q + BW'(1);
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs for the state being entered, so they can be registered.
   always_comb begin
      cls_d    = decode(word_d);
      alu_op_d = 3'b000;
      en_sc_d  = 1'b0;
      en_vs_d  = 1'b0;
      en_vv_d  = 1'b0;
      wb_en_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_d)
         S_ISSUE: begin
            busy_d   = 1'b1;
            alu_op_d = (cls_d == C_NOP) ? OP_NOP : word_d[2:0];
            en_sc_d  = (cls_d == C_SC);
            en_vs_d  = (cls_d == C_VS) || (cls_d == C_VDIV);
            en_vv_d  = (cls_d == C_VV);
            // A multi-cycle divide beat writes back on its last DIV_WAIT cycle.
            wb_en_d  = (cls_d != C_NOP) && !((cls_d == C_VDIV) && DIV_MULTI);
         end
         S_DIV_WAIT: begin
            busy_d   = 1'b1;
            alu_op_d = word_d[2:0];
            en_vs_d  = 1'b1;
            wb_en_d  = (cyc_d == LAST_CYC);
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State and registered outputs; reset abandons any instruction in flight.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         word_q   <= '0;
         beat_q   <= '0;
         cyc_q    <= '0;
         alu_op_q <= 3'b000;
         en_sc_q  <= 1'b0;
         en_vs_q  <= 1'b0;
         en_vv_q  <= 1'b0;
         wb_en_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         beat_q   <= beat_d;
         cyc_q    <= cyc_d;
         alu_op_q <= alu_op_d;
         en_sc_q  <= en_sc_d;
         en_vs_q  <= en_vs_d;
         en_vv_q  <= en_vv_d;
         wb_en_q  <= wb_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign alu_op      = alu_op_q;
   assign en_sc       = en_sc_q;
   assign en_vs       = en_vs_q;
   assign en_vv       = en_vv_q;
   assign beat_idx    = beat_q;
   assign wb_en       = wb_en_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Scoreboard bench for vec_exec_sequencer (VLEN=16, LANES=4, DIV_CYC=4).
// Stimulus pushes one expected record per busy/done cycle at each handshake;
// a negedge monitor pops and compares whenever busy, done or wb_en is high.
module tb_vec_exec_sequencer;

   localparam int VLEN    = 16;
   localparam int LANES   = 4;
   localparam int DIV_CYC = 4;
   localparam int NBEAT   = VLEN / LANES;
   localparam int FULL    = 1000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic       instr_ready;
   logic [4:0] exec_w;
   logic       flush;
   logic [2:0] alu_op;
   logic       en_sc, en_vs, en_vv;
   logic [1:0] beat_idx;
   logic       wb_en, busy, done;

   vec_exec_sequencer #(.VLEN(VLEN), .LANES(LANES), .DIV_CYC(DIV_CYC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .exec        (exec_w),
      .flush       (flush),
      .alu_op      (alu_op),
      .en_sc       (en_sc),
      .en_vs       (en_vs),
      .en_vv       (en_vv),
      .beat_idx    (beat_idx),
      .wb_en       (wb_en),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int pass_cnt = 0;
   int total    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   typedef struct {
      int         cyc;
      logic       is_done;
      logic [2:0] op;
      logic       sc, vs, vv, wb;
      logic [3:0] beat;
   } exp_t;

   exp_t sb_q[$];

   // Expected timeline of one instruction accepted at the edge sampled as t.
   // Only the first 'limit' busy cycles are pushed; done only if all are.
   function automatic void push_instr(input int t, input logic [4:0] w, input int limit);
      logic       func;
      logic [2:0] opc;
      int         beats, cpb, n;
      logic       sc, vs, vv;
      exp_t       e;
      func = w[4];
      opc  = w[3:1];
      beats = 1; cpb = 1; sc = 0; vs = 0; vv = 0;
      if (!func) begin
         case (opc)
            3'b001, 3'b100: begin vs = 1; beats = NBEAT; end
            3'b110:         begin vs = 1; beats = NBEAT; cpb = DIV_CYC; end
            3'b101:         begin vv = 1; beats = NBEAT; end
            default:        sc = 1;
         endcase
      end
      n = beats * cpb;
      for (int i = 0; i < n; i++) begin
         if (i < limit) begin
            e.cyc     = t + i;
            e.is_done = 1'b0;
            e.op      = func ? 3'b111 : opc;
            e.sc      = sc;
            e.vs      = vs;
            e.vv      = vv;
            e.wb      = !func && ((i % cpb) == cpb - 1);
            e.beat    = 4'(i / cpb);
            sb_q.push_back(e);
         end
      end
      if (n <= limit) begin
         e = '{cyc: t + n, is_done: 1'b1, op: 3'b000, sc: 1'b0, vs: 1'b0, vv: 1'b0, wb: 1'b0, beat: 4'd0};
         sb_q.push_back(e);
      end
   endfunction

   // Monitor: compare every busy/done/wb_en cycle with the next expected record.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (busy || done || wb_en)) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected", {25'd0, alu_op, busy, done, wb_en, en_vs}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_cycle", cyc_cnt, e.cyc);
            if (e.is_done)
               check("sb_done", {26'd0, en_sc, en_vs, en_vv, wb_en, done, busy},
                     {26'd0, 3'b000, 1'b0, 1'b1, 1'b0});
            else
               check("sb_beat", {18'd0, alu_op, en_sc, en_vs, en_vv, wb_en, done, busy, 2'b00, beat_idx},
                     {18'd0, e.op, e.sc, e.vs, e.vv, e.wb, 1'b0, 1'b1, e.beat});
         end
      end
   end

   // Called at a negedge; returns the sampled count after the accepting edge.
   task automatic issue(input logic [4:0] w, input logic fl, output int t);
      int waits;
      exec_w      = w;
      instr_valid = 1'b1;
      flush       = fl;
      waits       = 0;
      while (!instr_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      check("accept_wait", waits, 0);
      @(posedge clk);
      #1;
      t           = cyc_cnt;
      instr_valid = 1'b0;
      flush       = 1'b0;
      exec_w      = ~w;   // post-capture changes must be ignored
   endtask

   // Waits (bounded) for instr_ready and checks the cycle it came back.
   task automatic wait_idle(input int exp_cyc);
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!instr_ready && guard < 100);
      check("ready_back", cyc_cnt, exp_cyc);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {21'd0, instr_ready, alu_op, en_sc, en_vs, en_vv, beat_idx, wb_en, busy, done},
            {21'd0, 1'b1, 3'b000, 3'b000, 2'b00, 3'b000});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks", total);
      $fatal(1);
   end

   initial begin
      int t, t2, guard;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      exec_w      = 5'b0;
      flush       = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      @(negedge clk);

      // Scalar SUMA (opcode 010): 1 beat, done next, ready at T+3.
      issue(5'b00100, 1'b0, t);
      push_instr(t, 5'b00100, FULL);
      wait_idle(t + 2);

      // Vector-vector (opcode 101): 4 beats, then done.
      issue(5'b01010, 1'b0, t);
      push_instr(t, 5'b01010, FULL);
      wait_idle(t + NBEAT + 1);

      // Divide (opcode 110): 4 beats x 4 cycles, wb_en on each 4th cycle.
      issue(5'b01100, 1'b0, t);
      push_instr(t, 5'b01100, FULL);
      wait_idle(t + NBEAT * DIV_CYC + 1);

      // NOP (func=1): one cycle alu_op=111, no enables, no wb_en.
      issue(5'b10110, 1'b0, t);
      push_instr(t, 5'b10110, FULL);
      wait_idle(t + 2);

      // Scalar opcode 000 with exec[0]=1 (ignored bit).
      issue(5'b00001, 1'b0, t);
      push_instr(t, 5'b00001, FULL);
      wait_idle(t + 2);

      // Vector-scalar opcode 001 with flush held in IDLE (ignored).
      issue(5'b00010, 1'b1, t);
      push_instr(t, 5'b00010, FULL);
      wait_idle(t + NBEAT + 1);

      // Flush during beat 1 of opcode 100.
      issue(5'b01000, 1'b0, t);
      push_instr(t, 5'b01000, 2);
      @(negedge clk);             // beat 0
      @(negedge clk);             // beat 1
      check("flush_beat", {30'd0, beat_idx}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", {28'd0, instr_ready, busy, done, wb_en}, {28'd0, 4'b1000});
      issue(5'b01110, 1'b0, t2);  // scalar opcode 111, accepted at once
      check("flush_reaccept", t2, t + 3);
      push_instr(t2, 5'b01110, FULL);
      wait_idle(t2 + 2);

      // Reset in the middle of the divide: beat 2, third cycle.
      issue(5'b01100, 1'b0, t);
      push_instr(t, 5'b01100, 2 * DIV_CYC + 3);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (cyc_cnt != t + 2 * DIV_CYC + 2 && guard < 100);
      check("div_reach", cyc_cnt, t + 2 * DIV_CYC + 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Scalar after reset: normal latency.
      issue(5'b00110, 1'b0, t);
      push_instr(t, 5'b00110, FULL);
      wait_idle(t + 2);

      repeat (3) @(negedge clk);
      check("sb_drain", sb_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/vec_exec_sequencer.md
# vec_exec_sequencer

Sequences one vector-processor instruction at a time through the shared ALU datapath. It accepts a 5-bit exec word over a valid/ready handshake and decodes it into the ALU operation and the unit-enable class (scalar, vector-scalar, vector-vector). It then steps the vector datapath through VLEN/LANES element beats and emits a per-beat write-back strobe. It sits between the instruction decode stage and the ALU/lane array.

## Interface
- VLEN, 16: vector length in elements; must be a multiple of LANES.
- LANES, 4: elements processed per beat.
- DIV_CYC, 4: cycles per beat for vector/scalar division; minimum 1.
- NBEAT, VLEN/LANES (derived): beats per vector op; BW = max(1, clog2(NBEAT)).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  exec word valid
- instr_ready  out  1  sequencer can accept; high only in IDLE
- exec  in  5  instruction: func = exec[4], opcode = exec[3:1]; exec[0] ignored
- flush  in  1  synchronous abort of the current instruction
- alu_op  out  3  ALU operation code
- en_sc  out  1  scalar unit enable
- en_vs  out  1  vector-scalar unit enable
- en_vv  out  1  vector-vector adder enable
- beat_idx  out  BW  current beat; lanes beat_idx*LANES .. +LANES-1
- wb_en  out  1  write back current beat result this cycle
- busy  out  1  instruction in flight (ISSUE or DIV_WAIT)
- done  out  1  one-cycle completion pulse

## Operation
- Decode is performed on the captured word only. With func=0, alu_op = opcode, and the class is:
  - opcodes 000, 010, 011, 111: scalar; en_sc = 1; 1 beat.
  - opcodes 001, 100: vector-scalar; en_vs = 1; NBEAT beats of 1 cycle each.
  - opcode 110: vector-scalar divide; en_vs = 1; NBEAT beats of DIV_CYC cycles each.
  - opcode 101: vector-vector; en_vv = 1; NBEAT beats of 1 cycle each.
- func=1 is a NOP. alu_op = 111, all enables are 0, wb_en = 0, and it lasts 1 issue cycle.
- States and transitions:
  - IDLE: instr_ready = 1. On instr_valid && instr_ready, capture exec, clear beat_idx and the cycle counter, go to ISSUE.
  - ISSUE: drive alu_op and the enables. For a non-divide beat, assert wb_en (except NOP); then either advance beat_idx or, on the last beat, go to DONE. For divide, go to DIV_WAIT.
  - DIV_WAIT: hold alu_op, en_vs and beat_idx for the remaining DIV_CYC-1 cycles. Assert wb_en on the final cycle, then go to ISSUE with beat_idx+1, or to DONE after beat NBEAT-1. With DIV_CYC=1, DIV_WAIT is skipped and divide behaves like opcode 100.
  - DONE: done = 1, enables 0, wb_en 0; go to IDLE next cycle.
- beat_idx never exceeds NBEAT-1 and never wraps during an instruction.
- flush, sampled in ISSUE or DIV_WAIT, takes effect at the next edge:
  - go to IDLE directly; no done, no further wb_en.
  - the wb_en already asserted in the flush cycle stands.
  - flush in IDLE or DONE is ignored.
- exec and instr_valid changes after capture are ignored.
- Asynchronous reset at any time forces IDLE and abandons the instruction.

## Timing
- Reset values: instr_ready = 1; all other outputs 0 (alu_op = 000, beat_idx = 0).
- All outputs except instr_ready are registered; instr_ready = (state == IDLE).
- Handshake at edge T (accepted):
  - first ISSUE cycle is T+1.
  - scalar or NOP: done in cycle T+2; instr_ready high again at T+3.
  - non-divide vector op: beats in cycles T+1 .. T+NBEAT; done at T+NBEAT+1.
  - divide: beat k occupies cycles T+1+k*DIV_CYC .. T+(k+1)*DIV_CYC, with wb_en on the last of these; done at T+NBEAT*DIV_CYC+1.
- No back-to-back acceptance. The minimum interval between handshakes is latency+1 cycles (done cycle plus IDLE cycle).

## Test plan
- Reset release, then exec=5'b00100 (SUMA escalar), valid=1 for 1 cycle -> ISSUE: alu_op=010, en_sc=1, wb_en=1, beat_idx=0; done 1 cycle later; ready back 3 cycles after handshake.
- exec=5'b01010 (vector-vector SUMA), VLEN=16, LANES=4 -> 4 consecutive cycles: en_vv=1, wb_en=1, beat_idx 0,1,2,3; then done pulse; exactly 4 wb_en pulses.
- exec=5'b01100 (DIV), DIV_CYC=4 -> 16 cycles of en_vs=1 with alu_op=110; wb_en on cycles 4, 8, 12, 16 with beat_idx 0..3; done at cycle 17.
- exec=5'b1xxxx (func=1) -> one cycle alu_op=111, all enables 0, no wb_en; done next cycle.
- Start opcode 100, assert flush during beat_idx=1 -> beat 1 wb_en still seen; next cycle IDLE, instr_ready=1, no done; a new instruction is accepted immediately.
- Deassert rst_n mid-divide (beat 2, cycle 3) -> all outputs 0 immediately, instr_ready=1; after release, a scalar op completes with normal latency.
